// File: rtl/calc_sequencer.sv
// Four-bit pushbutton calculator: a debounced confirm button steps through
// operand A entry, operand B/op entry, a single calculate cycle and result display.
module calc_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_confirm,
    input  logic [3:0] sw,
    input  logic [1:0] op_sel,
    output logic       confirmed_operand1,
    output logic       confirmed_operand2,
    output logic [3:0] result,
    output logic       flag,
    output logic       busy
);

    typedef enum logic [1:0] {ENTER_A, ENTER_B, CALC, SHOW} state_t;

    localparam logic [23:0] CNT_LAST = 24'(DEBOUNCE_CYCLES - 1);

    logic [1:0]  sync_reg;
    logic        db_reg;
    logic        db_prev_reg;
    logic [23:0] cnt_reg;
    logic        press;

    state_t      state_reg;
    state_t      state_next;

    logic [3:0]  op_a_reg;
    logic [3:0]  op_b_reg;
    logic [1:0]  op_reg;
    logic        co1_reg;
    logic        co2_reg;
    logic [3:0]  result_reg;
    logic        flag_reg;

    logic [4:0]  sum;
    logic [7:0]  prod;
    logic [3:0]  result_next;
    logic        flag_next;

    // Synchroniser, then the debounced level only follows a run of mismatching samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg    <= 2'b00;
            db_reg      <= 1'b0;
            db_prev_reg <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            sync_reg    <= {sync_reg[0], btn_confirm};
            db_prev_reg <= db_reg;
            if (sync_reg[1] != db_reg) begin
                if (cnt_reg == CNT_LAST) begin
                    db_reg  <= sync_reg[1];
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 24'd1;
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign press = db_reg & ~db_prev_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ENTER_A;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        case (state_reg)
            ENTER_A: if (press) state_next = ENTER_B;
            ENTER_B: if (press) state_next = CALC;
            CALC: begin
                busy       = 1'b1;
                state_next = SHOW;
            end
            SHOW:    if (press) state_next = ENTER_A;
            default: state_next = ENTER_A;
        endcase
    end

    assign sum  = {1'b0, op_a_reg} + {1'b0, op_b_reg};
    assign prod = 8'(op_a_reg) * 8'(op_b_reg);

    always_comb begin
        result_next = 4'd0;
        flag_next   = 1'b0;
        case (op_reg)
            2'b00: begin
                result_next = sum[3:0];
                flag_next   = sum[4];
            end
            2'b01: begin
                result_next = op_a_reg - op_b_reg;
                flag_next   = (op_a_reg < op_b_reg);
            end
            2'b10: begin
                result_next = prod[3:0];
                flag_next   = |prod[7:4];
            end
            default: begin
                if (op_b_reg == 4'd0) begin
                    flag_next = 1'b1;
                end else begin
                    result_next = op_a_reg / op_b_reg;
                end
            end
        endcase
    end

    // Operands are captured only on accepted presses; results only on the CALC->SHOW edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a_reg   <= 4'd0;
            op_b_reg   <= 4'd0;
            op_reg     <= 2'd0;
            co1_reg    <= 1'b0;
            co2_reg    <= 1'b0;
            result_reg <= 4'd0;
            flag_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ENTER_A: begin
                    if (press) begin
                        op_a_reg <= sw;
                        co1_reg  <= 1'b1;
                    end
                end
                ENTER_B: begin
                    if (press) begin
                        op_b_reg <= sw;
                        op_reg   <= op_sel;
                    end
                end
                CALC: begin
                    result_reg <= result_next;
                    flag_reg   <= flag_next;
                    co2_reg    <= 1'b1;
                end
                SHOW: begin
                    if (press) begin
                        co1_reg    <= 1'b0;
                        co2_reg    <= 1'b0;
                        result_reg <= 4'd0;
                        flag_reg   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign confirmed_operand1 = co1_reg;
    assign confirmed_operand2 = co2_reg;
    assign result             = result_reg;
    assign flag               = flag_reg;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed and randomized checks of calc_sequencer against an arithmetic
// reference model, with debounce/latency timing derived from the button rules.
module tb_calc_sequencer;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_confirm;
    logic [3:0] sw;
    logic [1:0] op_sel;
    logic       confirmed_operand1;
    logic       confirmed_operand2;
    logic [3:0] result;
    logic       flag;
    logic       busy;

    int passed = 0;
    int total  = 0;
    int txn    = 0;
    int cur_a  = 0;

    calc_sequencer #(.DEBOUNCE_CYCLES(N)) dut (
        .clk               (clk),
        .reset             (reset),
        .btn_confirm       (btn_confirm),
        .sw                (sw),
        .op_sel            (op_sel),
        .confirmed_operand1(confirmed_operand1),
        .confirmed_operand2(confirmed_operand2),
        .result            (result),
        .flag              (flag),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    // Reference arithmetic: returns {flag, result}.
    function automatic logic [4:0] ref_calc(input int a, input int b, input int op);
        int r;
        int f;
        case (op)
            0: begin r = a + b; f = (r > 15) ? 1 : 0; r = r % 16; end
            1: begin f = (a < b) ? 1 : 0; r = (a - b + 16) % 16; end
            2: begin r = a * b; f = (r > 15) ? 1 : 0; r = r % 16; end
            default: begin
                if (b == 0) begin r = 0; f = 1; end
                else begin r = a / b; f = 0; end
            end
        endcase
        return 5'(f * 16 + r);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic enter_a(input int a, input bit bouncy);
        if (bouncy) begin
            sw = 4'(a);
            for (int k = 0; k < 6; k++) begin
                btn_confirm = 1'b1;
                tick($urandom_range(1, N - 1));
                btn_confirm = 1'b0;
                tick($urandom_range(1, N - 1));
            end
            tick(N);
        end
        sw = 4'(a);
        btn_confirm = 1'b1;
        tick(N + 2);
        check("co1_before_press", {7'd0, confirmed_operand1}, 8'd0);
        tick(1);
        check("co1_after_press", {7'd0, confirmed_operand1}, 8'd1);
        check("co2_in_enter_b", {7'd0, confirmed_operand2}, 8'd0);
        sw = 4'($urandom);
        tick(5);
        btn_confirm = 1'b0;
        tick(12);
        check("co1_held", {7'd0, confirmed_operand1}, 8'd1);
        check("busy_idle_b", {7'd0, busy}, 8'd0);
        cur_a = a;
    endtask

    task automatic enter_b(input int b, input int op);
        logic [4:0] exp;
        exp = ref_calc(cur_a, b, op);
        sw = 4'(b);
        op_sel = 2'(op);
        btn_confirm = 1'b1;
        tick(N + 2);
        check("busy_before_calc", {7'd0, busy}, 8'd0);
        tick(1);
        check("busy_in_calc", {7'd0, busy}, 8'd1);
        check("co2_in_calc", {7'd0, confirmed_operand2}, 8'd0);
        sw = 4'($urandom);
        op_sel = 2'($urandom);
        tick(1);
        check("co2_valid", {7'd0, confirmed_operand2}, 8'd1);
        check("result", {4'd0, result}, {4'd0, exp[3:0]});
        check("flag", {7'd0, flag}, {7'd0, exp[4]});
        check("busy_after_calc", {7'd0, busy}, 8'd0);
        tick(4);
        btn_confirm = 1'b0;
        sw = 4'($urandom);
        op_sel = 2'($urandom);
        tick(12);
        check("result_held", {3'd0, flag, result}, {3'd0, exp});
        check("co1_in_show", {7'd0, confirmed_operand1}, 8'd1);
        txn++;
        $display("txn %0d: a=%0d b=%0d op=%0d -> result=%0d flag=%0d (model %0d/%0d)",
                 txn, cur_a, b, op, result, flag, exp[3:0], exp[4]);
    endtask

    task automatic clear_press();
        sw = 4'($urandom);
        btn_confirm = 1'b1;
        tick(N + 2);
        check("co2_before_clear", {7'd0, confirmed_operand2}, 8'd1);
        tick(1);
        check("cleared_outputs", {4'd0, confirmed_operand1, confirmed_operand2, flag, busy},
              8'd0);
        check("cleared_result", {4'd0, result}, 8'd0);
        btn_confirm = 1'b0;
        tick(12);
        check("still_enter_a", {7'd0, confirmed_operand1}, 8'd0);
    endtask

    initial begin
        reset = 1'b1;
        btn_confirm = 1'b0;
        sw = 4'd0;
        op_sel = 2'd0;
        tick(3);
        check("reset_outputs", {3'd0, confirmed_operand1, confirmed_operand2, flag, busy, 1'b0},
              8'd0);
        check("reset_result", {4'd0, result}, 8'd0);
        reset = 1'b0;
        tick(2);

        // Add with carry, divide by zero, plain divide, multiply overflow.
        enter_a(9, 1'b0);  enter_b(8, 0);  clear_press();
        enter_a(7, 1'b0);  enter_b(0, 3);  clear_press();
        enter_a(13, 1'b0); enter_b(4, 3);  clear_press();
        enter_a(5, 1'b0);  enter_b(4, 2);  clear_press();

        // Regular bounce: toggles every 2 cycles for 20 cycles, then held high.
        sw = 4'd6;
        for (int k = 0; k < 5; k++) begin
            btn_confirm = 1'b1;
            tick(2);
            btn_confirm = 1'b0;
            tick(2);
        end
        btn_confirm = 1'b1;
        tick(10);
        check("bounce_co1", {7'd0, confirmed_operand1}, 8'd1);
        check("bounce_one_step", {6'd0, confirmed_operand2, busy}, 8'd0);
        btn_confirm = 1'b0;
        tick(12);
        check("bounce_no_extra", {6'd0, confirmed_operand2, busy}, 8'd0);
        cur_a = 6;
        enter_b(3, 1);
        clear_press();

        // Long hold in ENTER_A with switches moving throughout.
        sw = 4'd11;
        btn_confirm = 1'b1;
        tick(N + 3);
        for (int k = 0; k < 43; k++) begin
            sw = 4'($urandom);
            tick(1);
        end
        check("hold_co1", {7'd0, confirmed_operand1}, 8'd1);
        check("hold_one_step", {6'd0, confirmed_operand2, busy}, 8'd0);
        btn_confirm = 1'b0;
        tick(12);
        cur_a = 11;
        enter_b(2, 2);
        clear_press();

        // Randomized transactions, some with sub-threshold bounce ahead of the press.
        for (int t = 0; t < 10; t++) begin
            int a;
            int b;
            int op;
            a  = $urandom_range(0, 15);
            b  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15);
            op = $urandom_range(0, 3);
            enter_a(a, 1'($urandom_range(0, 1)));
            enter_b(b, op);
            clear_press();
        end

        // Reset during CALC with the button still held through reset release.
        enter_a(3, 1'b0);
        sw = 4'd5;
        op_sel = 2'd0;
        btn_confirm = 1'b1;
        tick(N + 3);
        check("calc_before_reset", {7'd0, busy}, 8'd1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("reset_mid_calc", {4'd0, confirmed_operand1, confirmed_operand2, flag, busy},
              8'd0);
        check("reset_mid_calc_result", {4'd0, result}, 8'd0);
        tick(N + 2);
        check("held_through_reset_early", {6'd0, confirmed_operand1, confirmed_operand2}, 8'd0);
        tick(1);
        check("held_through_reset_press", {6'd0, confirmed_operand1, confirmed_operand2}, 8'd2);
        btn_confirm = 1'b0;
        tick(12);
        check("co2_never_after_reset", {7'd0, confirmed_operand2}, 8'd0);
        txn++;
        $display("txn %0d: reset during CALC, held press after reset -> co1=%0d co2=%0d",
                 txn, confirmed_operand1, confirmed_operand2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 1_000_000, number of consecutive stable synchronised clk samples before a button level change is accepted; legal range 1..2^24-1.
REQ-002 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  reset, synchronous, active-high.
REQ-004 Port: btn_confirm  input  1  raw, asynchronous, bouncing confirm pushbutton.
REQ-005 Port: sw  input  4  operand value from switches; sampled only on an accepted confirm press.
REQ-006 Port: op_sel  input  2  operation select: 00 add, 01 subtract, 10 multiply, 11 divide; sampled only on the second accepted confirm press.
REQ-007 Port: confirmed_operand1  output  1  high once operand A is captured.
REQ-008 Port: confirmed_operand2  output  1  high once operand B is captured and result is valid.
REQ-009 Port: result  output  4  registered calculation result.
REQ-010 Port: flag  output  1  carry (add), borrow (sub), overflow (mul) or divide-by-zero (div) for the current result.
REQ-011 Port: busy  output  1  high only during the single CALC cycle.

Function
REQ-012 btn_confirm shall pass through a 2-flop synchroniser before any other use.
REQ-013 The debounced level shall change only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free sample resets the stability counter to 0.
REQ-014 An accepted press shall be a single-cycle internal pulse on the cycle the debounced level goes 0->1; release generates no pulse; holding the button generates exactly one pulse.
REQ-015 FSM states: ENTER_A, ENTER_B, CALC, SHOW.
REQ-016 ENTER_A: on accepted press, op_a <= sw, confirmed_operand1 <= 1, next ENTER_B; otherwise stay.
REQ-017 ENTER_B: on accepted press, op_b <= sw, op <= op_sel, next CALC; otherwise stay.
REQ-018 CALC: busy = 1, unconditional transition to SHOW after one cycle; result, flag and confirmed_operand2 <= 1 are registered on the CALC->SHOW edge.
REQ-019 Latency: result valid and confirmed_operand2 high exactly 2 clk cycles after the cycle carrying the second accepted press pulse.
REQ-020 SHOW: result/flag held constant; on accepted press, clear confirmed_operand1, confirmed_operand2, result, flag to 0, next ENTER_A; that press does not capture sw.
REQ-021 Add: result = (op_a+op_b) mod 16, flag = bit 4 of the 5-bit sum.
REQ-022 Subtract: result = (op_a-op_b) mod 16, flag = 1 iff op_a < op_b.
REQ-023 Multiply: result = low 4 bits of the 8-bit product, flag = 1 iff product > 15.
REQ-024 Divide: result = floor(op_a/op_b), flag = 0; if op_b = 0 then result = 0, flag = 1.
REQ-025 sw and op_sel changes outside accepted-press cycles shall have no effect on any output.
REQ-026 An accepted press in CALC is ignored (cannot occur for DEBOUNCE_CYCLES >= 1, but logic shall not depend on that).

Reset
REQ-027 reset high at a rising clk edge forces state ENTER_A, op_a/op_b/op cleared, confirmed_operand1 = 0, confirmed_operand2 = 0, result = 0, flag = 0, busy = 0, synchroniser flops = 0, debounced level = 0, stability counter = 0.
REQ-028 reset takes priority over every other event, including an accepted press in the same cycle and mid-CALC.
REQ-029 A button held through reset deassertion shall produce one accepted press DEBOUNCE_CYCLES+2 cycles after reset falls (debounced level restarts at 0).

Verification (DEBOUNCE_CYCLES = 4)
REQ-030 Add with carry: A=9, B=8, op_sel=00, clean presses -> confirmed_operand1 after press 1; result=1, flag=1, confirmed_operand2=1 exactly 2 cycles after press 2 pulse.
REQ-031 Divide by zero: A=7, B=0, op_sel=11 -> result=0, flag=1; A=13, B=4 -> result=3, flag=0.
REQ-032 Bounce: btn_confirm toggles every 2 cycles for 20 cycles then held high 10 cycles -> exactly one accepted press; state advances one step only.
REQ-033 Held button: btn_confirm high 50 cycles in ENTER_A -> only op_a captured, state ENTER_B; sw changes during hold ignored.
REQ-034 Multiply overflow then clear: A=5, B=4, op_sel=10 -> result=4, flag=1; third press -> all outputs 0, state ENTER_A.
REQ-035 Reset mid-operation: reset asserted on CALC cycle -> next cycle all outputs 0, confirmed_operand2 never asserts, state ENTER_A.
